// File: rtl/aes_io_pkg.sv
// Shared constants and state type for the AES-128 byte-serial host front end.
package aes_io_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_W      = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_KEY  = 3'd1,
        LOAD_DATA = 3'd2,
        KICK      = 3'd3,
        WAIT      = 3'd4,
        UNLOAD    = 3'd5
    } io_state_t;

endpackage

// File: rtl/aes_io_ctrl_if.sv
// Host-side streams of aes_io_ctrl: command, input byte stream, output byte stream.
interface aes_io_ctrl_if;
    import aes_io_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_encrypt;
    logic              cmd_new_key;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  cmd_valid, cmd_encrypt, cmd_new_key,
        input  in_valid, in_data,
        input  out_ready,
        output cmd_ready, in_ready,
        output out_valid, out_data, out_last
    );

    modport master (
        output cmd_valid, cmd_encrypt, cmd_new_key,
        output in_valid, in_data,
        output out_ready,
        input  cmd_ready, in_ready,
        input  out_valid, out_data, out_last
    );

endinterface

// File: rtl/aes_byte_ser.sv
// Parallel-load block serializer: presents the loaded block MSB byte first over valid/ready.
module aes_byte_ser
    import aes_io_pkg::*;
#(
    parameter int NBYTES = BLOCK_BYTES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [NBYTES*BYTE_W-1:0] din,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     done
);

    localparam int IW = $clog2(NBYTES);
    localparam int DW = NBYTES * BYTE_W;

    logic [DW-1:0] sh;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh        <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            sh        <= din;
            idx       <= '0;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            sh  <= sh << BYTE_W;
            idx <= idx + 1'b1;
            if (out_last)
                out_valid <= 1'b0;
        end
    end

    assign out_data = sh[DW-1 -: BYTE_W];
    assign out_last = out_valid && (idx == IW'(NBYTES - 1));
    assign done     = out_valid && out_ready && out_last;

endmodule

// File: rtl/aes_io_ctrl.sv
// Byte-serial command/key/data loader and result unloader around the AES-128 iterative core.
module aes_io_ctrl
    import aes_io_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    aes_io_ctrl_if.slave                  bus,
    output logic [BLOCK_BYTES*BYTE_W-1:0] key_o,
    output logic [BLOCK_BYTES*BYTE_W-1:0] data_o,
    output logic                          sel_cypher,
    output logic                          key_change,
    output logic                          start,
    input  logic                          core_done,
    input  logic [BLOCK_BYTES*BYTE_W-1:0] core_result,
    output logic                          busy,
    output logic                          error
);

    localparam int BLK_W = BLOCK_BYTES * BYTE_W;
    localparam int TW    = $clog2(TIMEOUT + 1);

    io_state_t     state;
    logic [3:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic          key_loaded;

    logic          cmd_hs;
    logic          in_hs;
    logic          last_byte;
    logic          ser_load;
    logic          ser_done;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.in_ready  = (state == LOAD_KEY) || (state == LOAD_DATA);
    assign cmd_hs        = bus.cmd_valid && bus.cmd_ready;
    assign in_hs         = bus.in_valid && bus.in_ready;
    assign last_byte     = (bcnt == 4'(BLOCK_BYTES - 1));
    assign start         = (state == KICK);
    assign busy          = (state != IDLE);
    assign ser_load      = (state == WAIT) && core_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            key_o      <= '0;
            data_o     <= '0;
            sel_cypher <= 1'b0;
            key_change <= 1'b0;
            error      <= 1'b0;
            key_loaded <= 1'b0;
            bcnt       <= '0;
            tcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        sel_cypher <= bus.cmd_encrypt;
                        key_change <= bus.cmd_new_key;
                        error      <= 1'b0;
                        bcnt       <= '0;
                        if (bus.cmd_new_key)
                            state <= LOAD_KEY;
                        else if (key_loaded)
                            state <= LOAD_DATA;
                        else
                            error <= 1'b1;
                    end
                end
                LOAD_KEY: begin
                    if (in_hs) begin
                        key_o <= {key_o[BLK_W-BYTE_W-1:0], bus.in_data};
                        bcnt  <= bcnt + 1'b1;
                        if (last_byte) begin
                            key_loaded <= 1'b1;
                            bcnt       <= '0;
                            state      <= LOAD_DATA;
                        end
                    end
                end
                LOAD_DATA: begin
                    if (in_hs) begin
                        data_o <= {data_o[BLK_W-BYTE_W-1:0], bus.in_data};
                        bcnt   <= bcnt + 1'b1;
                        if (last_byte) begin
                            bcnt  <= '0;
                            state <= KICK;
                        end
                    end
                end
                KICK: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // completion wins over timeout when both land on the same cycle
                    if (core_done) begin
                        state <= UNLOAD;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (ser_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    aes_byte_ser #(
        .NBYTES (BLOCK_BYTES)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .din       (core_result),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_aes_io_ctrl.sv
// Self-checking bench for aes_io_ctrl with a stand-in core and a transaction-level host model.
module tb_aes_io_ctrl;
    import aes_io_pkg::*;

    localparam int TIMEOUT = 64;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] key_o, data_o, core_result;
    logic         sel_cypher, key_change, start, core_done, busy, error;

    aes_io_ctrl_if bus();

    aes_io_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .key_o       (key_o),
        .data_o      (data_o),
        .sel_cypher  (sel_cypher),
        .key_change  (key_change),
        .start       (start),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy),
        .error       (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // stand-in for the AES core: a known vector pair plus a fixed scramble otherwise
    function automatic logic [127:0] core_fn(input logic enc, input logic [127:0] k, input logic [127:0] d);
        if (enc && k == K0 && d == PT) return CT;
        if (!enc && k == K0 && d == CT) return PT;
        return {d[63:0], d[127:64]} ^ k ^ {128{enc}};
    endfunction

    // start pulses counted on the edge that ends the KICK cycle
    int start_cnt = 0;
    int start_cyc = -1;
    always @(posedge clk) begin
        if (start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
    end

    bit           core_hang = 1'b0;
    bit           stray_req = 1'b0;
    int           done_cyc  = -1;
    logic [127:0] cap_key, cap_data;
    logic         cap_sel, cap_kc;

    initial begin
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (stray_req) begin
                core_done   = 1'b1;
                core_result = '1;
                stray_req   = 1'b0;
            end else if (start === 1'b1) begin
                cap_key  = key_o;
                cap_data = data_o;
                cap_sel  = sel_cypher;
                cap_kc   = key_change;
                if (!core_hang) begin
                    repeat ($urandom_range(1, 8)) @(negedge clk);
                    core_done   = 1'b1;
                    core_result = core_fn(cap_sel, cap_key, cap_data);
                    done_cyc    = cyc;
                end
            end
        end
    end

    // host-side reference state
    bit           m_key_loaded = 1'b0;
    logic [127:0] m_key = '0;

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_busy"},      busy, 0);
        check_eq({pfx, "_error"},     error, 0);
        check_eq({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
        check_eq({pfx, "_in_ready"},  bus.in_ready, 0);
        check_eq({pfx, "_start"},     start, 0);
        check_eq({pfx, "_key_o"},     key_o, 0);
        check_eq({pfx, "_data_o"},    data_o, 0);
        check_eq({pfx, "_sel"},       sel_cypher, 0);
        check_eq({pfx, "_kc"},        key_change, 0);
        check_eq({pfx, "_out_valid"}, bus.out_valid, 0);
        check_eq({pfx, "_out_last"},  bus.out_last, 0);
    endtask

    task automatic send_cmd(input logic enc, input logic nk);
        int t = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_encrypt = enc;
        bus.cmd_new_key = nk;
        while (bus.cmd_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_eq("cmd_ready_timeout", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_eq("in_ready_timeout", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk);
        for (int i = 0; i < 16; i++) send_byte(blk[127 - 8*i -: 8]);
    endtask

    // mode 0: random out_ready; mode 1: stall 10 cycles on byte 0, then every other cycle
    task automatic recv_block(input int mode, input logic [127:0] exp);
        int   got  = 0;
        int   t    = 0;
        int   k    = 0;
        bit   seen = 1'b0;
        logic r;
        while (got < 16 && t < 2000) begin
            if (bus.out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                check_eq("valid_latency", cyc, done_cyc + 1);
            end
            if (mode == 1) r = seen && (k >= 10) && ((k - 10) % 2 == 0);
            else           r = 1'($urandom_range(0, 1));
            if (seen) k++;
            bus.out_ready = r;
            if (bus.out_valid === 1'b1) begin
                check_eq($sformatf("out_byte%0d", got), bus.out_data, exp[127 - 8*got -: 8]);
                check_eq($sformatf("out_last%0d", got), bus.out_last, got == 15);
                if (r) got++;
            end
            @(negedge clk);
            t++;
        end
        bus.out_ready = 1'b0;
        check_eq("out_count", got, 16);
        check_eq("post_out_valid", bus.out_valid, 0);
        check_eq("post_busy", busy, 0);
        check_eq("post_cmd_ready", bus.cmd_ready, 1);
    endtask

    task automatic run_txn(input logic enc, input logic nk, input logic [127:0] key,
                           input logic [127:0] data, input int omode);
        int           sc0 = start_cnt;
        int           t   = 0;
        logic [127:0] exp;
        send_cmd(enc, nk);
        if (!nk && !m_key_loaded) begin
            check_eq("nokey_error", error, 1);
            check_eq("nokey_busy", busy, 0);
            repeat (5) @(negedge clk);
            check_eq("nokey_idle", bus.cmd_ready, 1);
            check_eq("nokey_no_start", start_cnt, sc0);
            return;
        end
        check_eq("err_clr", error, 0);
        check_eq("cmd_busy", busy, 1);
        check_eq("cmd_sel", sel_cypher, enc);
        check_eq("cmd_kc", key_change, nk);
        if (nk) begin
            send_block(key);
            m_key        = key;
            m_key_loaded = 1'b1;
        end
        send_block(data);
        check_eq("start_after_last", start, 1);
        exp = core_fn(enc, m_key, data);
        if (core_hang) begin
            while (error !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
            end
            check_eq("timeout_cycles", cyc - start_cyc - 1, TIMEOUT);
            check_eq("timeout_busy", busy, 0);
            check_eq("timeout_cmd_ready", bus.cmd_ready, 1);
        end else begin
            recv_block(omode, exp);
            check_eq("hold_key", key_o, m_key);
            check_eq("hold_data", data_o, data);
        end
        check_eq("start_once", start_cnt, sc0 + 1);
        check_eq("core_key", cap_key, m_key);
        check_eq("core_data", cap_data, data);
        check_eq("core_sel", cap_sel, enc);
        check_eq("core_kc", cap_kc, nk);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int sc0;
        logic [127:0] rk;
        bus.cmd_valid   = 1'b0;
        bus.cmd_encrypt = 1'b0;
        bus.cmd_new_key = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // bytes offered while idle must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hee;
        repeat (3) @(negedge clk);
        check_eq("idle_in_ready", bus.in_ready, 0);
        check_eq("idle_busy", busy, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 1'b1, K0, PT, 0);
        run_txn(1'b0, 1'b0, '0, CT, 0);

        // no key loaded after reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_key_loaded = 1'b0;
        @(negedge clk);
        run_txn(1'b1, 1'b0, '0, PT, 0);
        run_txn(1'b1, 1'b1, rand128(), rand128(), 0);

        // core never completes
        core_hang = 1'b1;
        run_txn(1'b1, 1'b0, '0, rand128(), 0);
        core_hang = 1'b0;
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("stray_done_busy", busy, 0);
        check_eq("stray_done_valid", bus.out_valid, 0);

        run_txn(1'b0, 1'b0, '0, rand128(), 1);

        // asynchronous reset mid LOAD_DATA
        sc0 = start_cnt;
        send_cmd(1'b1, 1'b1);
        rk = rand128();
        send_block(rk);
        for (int i = 0; i < 7; i++) send_byte(rk[127 - 8*i -: 8]);
        check_eq("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_key_loaded = 1'b0;
        @(negedge clk);
        check_eq("arst_no_start", start_cnt, sc0);
        run_txn(1'b0, 1'b0, '0, rand128(), 0);

        for (int n = 0; n < 8; n++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rand128(), rand128(), int'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
